// File: rtl/pbl_pkg.sv
// Shared definitions for the program-control blocks: instruction address width,
// the address type used by the PC and return stack, and the default stack depth.
package pbl_pkg;

    localparam int INSTR_ADDR_SIZE = 5;
    localparam int RET_STACK_DEPTH = 8;

    typedef logic [INSTR_ADDR_SIZE-1:0] instr_addr_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack for the PC: pushes instr_addr+1 on call, pops on ret,
// and presents the top entry combinationally so the PC loads it on the ret edge.
module ret_stack #(
    parameter int INSTR_ADDR_SIZE = pbl_pkg::INSTR_ADDR_SIZE,
    parameter int STACK_DEPTH     = pbl_pkg::RET_STACK_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               call,
    input  logic                               ret,
    input  logic [INSTR_ADDR_SIZE-1:0]         instr_addr,
    output logic [INSTR_ADDR_SIZE-1:0]         ret_addr,
    output logic                               empty,
    output logic                               full,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   level,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int LW = $clog2(STACK_DEPTH + 1);
    localparam int PW = $clog2(STACK_DEPTH);

    // call and ret are single-cycle strobes with no backpressure: each cycle
    // either is high it is consumed at the next posedge; call wins over ret.

    logic [INSTR_ADDR_SIZE-1:0] mem [STACK_DEPTH];
    logic [INSTR_ADDR_SIZE-1:0] link;
    logic [PW-1:0]              wr_idx;
    logic [PW-1:0]              top_idx;
    logic                       push;

    assign link    = instr_addr + INSTR_ADDR_SIZE'(1);
    assign wr_idx  = PW'(level);
    assign top_idx = PW'(level - LW'(1));
    assign push    = call && !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (call) begin
            if (!full) begin
                level <= level + LW'(1);
            end else begin
                overflow <= 1'b1;
            end
        end else if (ret) begin
            if (!empty) begin
                level <= level - LW'(1);
            end else begin
                underflow <= 1'b1;
            end
        end
    end

    // Entries are never cleared; level alone defines what is live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_idx] <= link;
        end
    end

    assign empty    = (level == LW'(0));
    assign full     = (level == LW'(STACK_DEPTH));
    assign ret_addr = empty ? '0 : mem[top_idx];

endmodule
